// File: rtl/cpu_pkg.sv
// Shared types and default sizing for the instruction fetch front end.
package cpu_pkg;

  // Memory-side request tracking for the fetch unit.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam int          FETCH_DEPTH    = 4;
  localparam int          FETCH_IW       = 30;
  localparam int          FETCH_AW       = 32;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO between instruction memory and decode. Each entry holds an
// instruction and the PC+4 that belongs to it. Storage is not reset; only the
// pointers and occupancy count are.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int  DEPTH = FETCH_DEPTH,
  parameter int  IW    = FETCH_IW,
  parameter int  AW    = FETCH_AW,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq,
  input  logic [IW-1:0]    enq_instr,
  input  logic [AW-1:0]    enq_pc,
  input  logic             deq,
  input  logic             flush,
  output logic [IW-1:0]    head_instr,
  output logic [AW-1:0]    head_pc,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [IW+AW-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_enq;
  logic             do_deq;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A flush wins over any same-cycle push or pop; a push into a full queue
  // is only accepted when the head leaves in the same cycle.
  assign do_enq = enq && (!full || deq) && !flush;
  assign do_deq = deq && !empty && !flush;

  assign {head_instr, head_pc} = mem[rd_ptr];

  // Entry storage: written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem[wr_ptr] <= {enq_instr, enq_pc};
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_enq, do_deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: keeps the fetch PC, issues at most one memory
// request at a time, and buffers returned instructions for decode. Redirects
// from execute or writeback flush the buffer and mark any in-flight response
// as stale so it is dropped on arrival.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = FETCH_DEPTH,
  parameter int          IW       = FETCH_IW,
  parameter int          AW       = FETCH_AW,
  parameter logic [AW-1:0] RESET_PC = AW'(FETCH_RESET_PC)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  input  logic          PCWrPendingF,
  input  logic          BranchTakenE,
  input  logic [AW-1:0] BranchTargetE,
  input  logic          PCSrcW,
  input  logic [AW-1:0] PCResultW,
  input  logic          StallD,
  output logic [IW-1:0] InstrD,
  output logic [AW-1:0] PCPlus4D,
  output logic          InstrValidD
);

  localparam int               CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_state_t     state;
  fetch_state_t     next_state;
  logic [AW-1:0]    pc;
  logic             redirect;
  logic [AW-1:0]    redirect_target;
  logic             issue;
  logic             enq;
  logic             deq;

  logic [IW-1:0]    q_head_instr;
  logic [AW-1:0]    q_head_pc;
  logic             q_full;
  logic             q_empty;
  logic [CNT_W-1:0] q_count;

  // Writeback redirects are older than execute redirects, so they win.
  assign redirect        = PCSrcW | BranchTakenE;
  assign redirect_target = PCSrcW ? PCResultW : BranchTargetE;

  // Requests are held off during reset so the first one appears exactly in
  // the first cycle reset is released.
  assign issue = reset && (state == IDLE) && (q_count < DEPTH_C) &&
                 !PCWrPendingF && !redirect;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a redirect while waiting turns the pending response stale.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (issue) begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          next_state = IDLE;
        end else if (redirect) begin
          next_state = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_ack) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode: request strobe, fresh-response capture and decode consumption.
  always_comb begin
    imem_req  = issue;
    imem_addr = pc;
    enq       = (state == WAIT) && imem_ack && !redirect;
    deq       = !q_empty && !StallD;
  end

  // Fetch PC: redirect target, or advance past the address just requested.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_target;
    end else if (issue) begin
      pc <= pc + AW'(4);
    end
  end

  // By the time a response returns, pc already holds request address + 4,
  // which is exactly the PC+4 decode wants alongside the instruction.
  fetch_queue #(
    .DEPTH (DEPTH),
    .IW    (IW),
    .AW    (AW)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .enq        (enq),
    .enq_instr  (imem_rdata),
    .enq_pc     (pc),
    .deq        (deq),
    .flush      (redirect),
    .head_instr (q_head_instr),
    .head_pc    (q_head_pc),
    .full       (q_full),
    .empty      (q_empty),
    .count      (q_count)
  );

  assign InstrValidD = !q_empty;
  assign InstrD      = q_empty ? '0 : q_head_instr;
  assign PCPlus4D    = q_empty ? '0 : q_head_pc;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- DEPTH, 4: prefetch queue entries, power of two.
- IW, 30: instruction width.
- AW, 32: PC width, byte address.
- RESET_PC, 0: PC value after reset.

REQ-002 Ports, one per line: name, direction, width, meaning:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- imem_req  out  1  one-cycle request strobe to instruction memory.
- imem_addr  out  AW  request address; valid when imem_req=1.
- imem_ack  in  1  response valid; latency >=1 cycle after imem_req.
- imem_rdata  in  IW  response instruction; valid when imem_ack=1.
- PCWrPendingF  in  1  PC write in flight; blocks new requests.
- BranchTakenE  in  1  execute-stage redirect.
- BranchTargetE  in  AW  execute redirect target.
- PCSrcW  in  1  writeback-stage redirect.
- PCResultW  in  AW  writeback redirect target.
- StallD  in  1  decode not consuming this cycle.
- InstrD  out  IW  head-of-queue instruction to decode; 0 when invalid.
- PCPlus4D  out  AW  PC+4 of InstrD; 0 when invalid.
- InstrValidD  out  1  queue non-empty.

Function
REQ-003 FSM states: IDLE (no request outstanding), WAIT (one request outstanding), DISCARD (outstanding response is stale).
REQ-004 At most one memory request shall be outstanding at any time.
REQ-005 Issue condition: imem_req=1 iff state=IDLE, count<DEPTH, PCWrPendingF=0 and no redirect this cycle.
- Then imem_addr=PC; next cycle PC<=PC+4 and state=WAIT.
REQ-006 WAIT with imem_ack=1 and no redirect: enqueue {imem_rdata, PC}, where PC already equals request address+4; state<=IDLE.
REQ-007 Dequeue when InstrValidD=1 and StallD=0. Simultaneous enqueue and dequeue keeps count unchanged.
REQ-008 Redirect = PCSrcW | BranchTakenE.
- Target: PCResultW when PCSrcW=1 (PCSrcW wins), else BranchTargetE.
- On redirect, next cycle: PC<=target; queue emptied; dequeue ignored.
REQ-009 Redirect state transitions:
- IDLE -> IDLE.
- WAIT without ack -> DISCARD.
- WAIT with ack -> IDLE, data dropped.
- DISCARD without ack -> DISCARD.
- DISCARD with ack -> IDLE.
REQ-010 DISCARD with imem_ack=1 and no redirect: drop data; state<=IDLE.
REQ-011 Queue full (count=DEPTH): no request issued. Count never exceeds DEPTH.
REQ-012 PCWrPendingF=1: outstanding request still completes and enqueues; no new issue.
REQ-013 PC arithmetic is modulo 2^AW; PC+4 wraps silently.
REQ-014 Queue pointers wrap modulo DEPTH.

Reset
REQ-015 reset=0 at a clock edge shall set:
- PC=RESET_PC, state=IDLE, count=0, pointers=0.
- imem_req=0, InstrValidD=0, InstrD=0, PCPlus4D=0.
REQ-016 reset=0 overrides redirect, ack and dequeue. An ack arriving in the first cycle after reset is discarded.
REQ-017 The first request shall issue, with imem_addr=RESET_PC, in the first cycle with reset=1.

Structure
REQ-018 Package cpu_pkg shall hold fetch_state_t (IDLE, WAIT, DISCARD) and the default constants for DEPTH, IW, AW and RESET_PC.
REQ-019 One sub-module, fetch_queue: synchronous FIFO with enq, deq, flush, full, empty and count. The FSM and PC logic stay in fetch_unit.

Verification
REQ-020 Reset release, 1-cycle ack, StallD=0:
- imem_addr sequence 0, 4, 8, ...
- InstrD follows in order; PCPlus4D = 4, 8, 12, ...
REQ-021 StallD=1 held:
- After exactly 4 enqueues, imem_req stays 0.
- Release StallD: the 5th request issues with addr 0x10.
REQ-022 Redirect while WAIT:
- Request at 0x8; BranchTakenE=1, BranchTargetE=0x100 before ack.
- Ack data for 0x8 is dropped; next imem_addr=0x100; queue empty.
REQ-023 Same-cycle redirects:
- PCSrcW=1 (PCResultW=0x200) with BranchTakenE=1 (0x300).
- Next imem_addr=0x200.
REQ-024 PCWrPendingF=1 for 3 cycles while a request is outstanding:
- Response is enqueued.
- No imem_req until PCWrPendingF=0.
REQ-025 reset=0 asserted in WAIT with a full queue:
- Next cycle: InstrValidD=0, state IDLE.
- First request after release at RESET_PC.
